// File: rtl/pulse_generator.sv
// pulse_generator: emits one clean pulse per accepted request. The high phase
// lasts max(length, high_count) enable ticks and is always followed by a low
// guard of low_count enable ticks, so the output meets a downstream
// minimum-high / minimum-low filter.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-low reset
//   enable  in   timebase tick; countdown advances only when enable=1
//   start   in   pulse request, accepted when ready=1
//   length  in   requested high duration in ticks, sampled on acceptance
//   ready   out  idle and able to accept start (registered)
//   out     out  generated pulse (registered)
//   done    out  one-cycle strobe when the low guard completes (registered)
module pulse_generator #(
   parameter int unsigned high_count   = 4,
   parameter int unsigned low_count    = 4,
   parameter int unsigned length_width = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    start,
   input  logic [length_width-1:0] length,
   output logic                    ready,
   output logic                    out,
   output logic                    done
);

   // Counter must hold the widest of the request, the clamp and the guard.
   localparam int unsigned high_bits   = $clog2(high_count + 1);
   localparam int unsigned low_bits    = $clog2(low_count + 1);
   localparam int unsigned hl_bits     = (high_bits > low_bits) ? high_bits : low_bits;
   localparam int unsigned count_width = (length_width > hl_bits) ? length_width : hl_bits;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [count_width-1:0] counter;
   logic [count_width-1:0] counter_next;
   logic                   out_next;
   logic                   ready_next;
   logic                   done_next;

   logic [count_width-1:0] length_ext;
   logic [count_width-1:0] high_min;
   logic [count_width-1:0] low_load;
   logic [count_width-1:0] pulse_len;
   logic                   count_last;

   assign length_ext = count_width'(length);
   assign high_min   = count_width'(high_count);
   assign low_load   = count_width'(low_count);
   // Clamp short requests (including zero) up to the minimum high time.
   assign pulse_len  = (length_ext > high_min) ? length_ext : high_min;
   assign count_last = (counter == count_width'(1));

   // State, counter and output registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
         out     <= 1'b0;
         ready   <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         out     <= out_next;
         ready   <= ready_next;
         done    <= done_next;
      end
   end

   // Next-state and countdown.
   always_comb begin
      state_next   = state;
      counter_next = counter;
      case (state)
         IDLE: begin
            // Acceptance is independent of enable.
            if (start) begin
               state_next   = HIGH;
               counter_next = pulse_len;
            end
         end
         HIGH: begin
            if (enable) begin
               if (count_last) begin
                  state_next   = LOW;
                  counter_next = low_load;
               end else begin
                  counter_next = counter - count_width'(1);
               end
            end
         end
         LOW: begin
            if (enable) begin
               if (count_last) begin
                  state_next   = IDLE;
                  counter_next = '0;
               end else begin
                  counter_next = counter - count_width'(1);
               end
            end
         end
         default: begin
            state_next   = IDLE;
            counter_next = '0;
         end
      endcase
   end

   // Output values derived from the upcoming state so the registered outputs
   // line up with the state they describe.
   always_comb begin
      out_next   = 1'b0;
      ready_next = 1'b0;
      done_next  = 1'b0;
      out_next   = (state_next == HIGH);
      ready_next = (state_next == IDLE);
      done_next  = (state == LOW) && (state_next == IDLE);
   end

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed bench for pulse_generator with default
// parameters (high_count=4, low_count=4, length_width=8).
module tb_pulse_generator;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       start;
   logic [7:0] length;
   logic       ready;
   logic       out;
   logic       done;

   int total  = 0;
   int bad    = 0;
   int cyc    = 0;
   int en_div = 1;

   int   hc, ht, lc, lt, rv;

   pulse_generator #(
      .high_count  (4),
      .low_count   (4),
      .length_width(8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .start (start),
      .length(length),
      .ready (ready),
      .out   (out),
      .done  (done)
   );

   always #5 clock = ~clock;

   // Advance one clock, settle, then set enable for the following edge.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      enable = (en_div <= 1) ? 1'b1 : ((cyc % en_div) == 0);
   endtask

   function automatic logic [31:0] status();
      return 32'({out, ready, done});
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts on the first sampled HIGH cycle; returns clock and enable-tick
   // counts of the high and low phases and stops on the sampled done cycle.
   task automatic measure(input bit poke, input bit hold,
                          output int hc_o, output int ht_o,
                          output int lc_o, output int lt_o, output int rv_o);
      hc_o = 0; ht_o = 0; lc_o = 0; lt_o = 0; rv_o = 0;
      while (out === 1'b1 && hc_o < 200) begin
         hc_o++;
         if (enable) ht_o++;
         if (ready !== 1'b0) rv_o++;
         start = poke | hold;
         tick();
      end
      while (out === 1'b0 && done !== 1'b1 && lc_o < 200) begin
         lc_o++;
         if (enable) lt_o++;
         if (ready !== 1'b0) rv_o++;
         start = hold | (poke && lc_o == 1);
         tick();
      end
      start = hold;
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      start  = 1'b1;
      length = 8'd50;

      // Reset wins over a pending start.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", status(), 32'b010);
      end
      start = 1'b0;
      reset = 1'b1;
      tick();
      check("after_reset", status(), 32'b010);

      // Basic pulse, length=10, enable always on; length change after accept.
      en_div = 1;
      enable = 1'b1;
      length = 8'd10;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      length = 8'd99;
      check("basic_accept", status(), 32'b100);
      for (int i = 1; i < 10; i++) begin
         tick();
         check("basic_high", status(), 32'b100);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         check("basic_guard", status(), 32'b000);
      end
      tick();
      check("basic_done", status(), 32'b011);
      tick();
      check("basic_idle", status(), 32'b010);

      // Minimum clamp: length 0 and 2 both give high_count.
      for (int k = 0; k < 2; k++) begin
         length = (k == 0) ? 8'd0 : 8'd2;
         start  = 1'b1;
         tick();
         start  = 1'b0;
         measure(1'b0, 1'b0, hc, ht, lc, lt, rv);
         check("clamp_high_clk", 32'(hc), 32'd4);
         check("clamp_low_clk", 32'(lc), 32'd4);
         check("clamp_done", status(), 32'b011);
         check("clamp_ready_busy", 32'(rv), 32'd0);
         tick();
         check("clamp_idle", status(), 32'b010);
      end

      // Sparse enable: every third cycle, length=5.
      en_div = 3;
      length = 8'd5;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      measure(1'b0, 1'b0, hc, ht, lc, lt, rv);
      check("sparse_high_ticks", 32'(ht), 32'd5);
      check("sparse_high_clk_range", 32'(hc >= 13 && hc <= 17), 32'd1);
      check("sparse_low_ticks", 32'(lt), 32'd4);
      check("sparse_done", status(), 32'b011);
      check("sparse_ready_busy", 32'(rv), 32'd0);
      tick();
      check("sparse_idle", status(), 32'b010);
      en_div = 1;
      enable = 1'b1;

      // Start poked during HIGH and LOW is ignored.
      length = 8'd5;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      measure(1'b1, 1'b0, hc, ht, lc, lt, rv);
      check("ignore_high_clk", 32'(hc), 32'd5);
      check("ignore_low_clk", 32'(lc), 32'd4);
      check("ignore_done", status(), 32'b011);
      check("ignore_ready_busy", 32'(rv), 32'd0);
      tick();
      check("ignore_no_second", status(), 32'b010);

      // Back-to-back with start held, length=6, five pulses.
      length = 8'd6;
      start  = 1'b1;
      for (int p = 0; p < 5; p++) begin
         tick();
         measure(1'b0, 1'b1, hc, ht, lc, lt, rv);
         check("b2b_high_clk", 32'(hc), 32'd6);
         check("b2b_low_clk", 32'(lc), 32'd4);
         check("b2b_done", status(), 32'b011);
         check("b2b_ready_busy", 32'(rv), 32'd0);
      end
      start = 1'b0;
      tick();
      check("b2b_stop_idle", status(), 32'b010);

      // Reset in the middle of HIGH.
      length = 8'd10;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      tick();
      check("midhigh_running", status(), 32'b100);
      reset = 1'b0;
      tick();
      check("midhigh_reset", status(), 32'b010);
      reset = 1'b1;
      tick();
      check("midhigh_released", status(), 32'b010);
      length = 8'd0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      measure(1'b0, 1'b0, hc, ht, lc, lt, rv);
      check("post_reset_high_clk", 32'(hc), 32'd4);
      check("post_reset_done", status(), 32'b011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
